ram_arbiter: RTL

Two-requester arbiter and access sequencer for the single-port RAM on the multi-cycle board. It shares the RAM port between requester 0 (the processor) and requester 1 (an auxiliary master such as the display/debug reader). It serialises one transaction at a time, sequences the read latency, and returns one `ack` pulse per completed access. The arbiter sits between the masters and the memory block and drives the RAM port exclusively.

---
 rtl/ram_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between two requesters,
// serialising accesses and sequencing the read latency.
module ram_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int READ_LAT  = 1,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              req0,
  input  logic              req1,
  input  logic              rwN0,
  input  logic              rwN1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_readwriteN,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy,
  output logic              grant
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              ram_rwn_q, ram_rwn_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;

  logic              win;
  logic              win_rwn;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // last_q remembers the previous owner so a tie goes to the other one
  assign win = (FIXED_PRI != 0) ? ~req0
             : ((req0 & req1) ? ~last_q : req1);

  assign win_rwn   = win ? rwN1   : rwN0;
  assign win_addr  = win ? addr1  : addr0;
  assign win_wdata = win ? wdata1 : wdata0;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    ram_rwn_d  = 1'b1;
    ram_addr_d = '0;
    ram_din_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          grant_d    = win;
          last_d     = win;
          wr_d       = ~win_rwn;
          cnt_d      = CNT_W'(READ_LAT);
          ram_rwn_d  = win_rwn;
          ram_addr_d = win_addr;
          ram_din_d  = win_rwn ? '0 : win_wdata;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (wr_q || cnt_q == '0) begin
          state_d = RESP;
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          if (!wr_q) begin
            if (grant_q) rdata1_d = ram_data_out;
            else         rdata0_d = ram_data_out;
          end
        end else begin
          cnt_d      = cnt_q - 1'b1;
          ram_rwn_d  = 1'b1;
          ram_addr_d = ram_addr_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      ram_rwn_q  <= 1'b1;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      ram_rwn_q  <= ram_rwn_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
    end
  end

  assign ack0           = ack0_q;
  assign ack1           = ack1_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;
  assign ram_readwriteN = ram_rwn_q;
  assign ram_address    = ram_addr_q;
  assign ram_data_in    = ram_din_q;
  assign busy           = (state_q != IDLE);
  assign grant          = grant_q;

endmodule
